// File: rtl/md_pkg.sv
// Shared MD opcode encoding, request type and opcode classifiers for the
// E-stage multiply/divide dispatch logic.
package md_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;
    localparam logic [3:0] MD_BDS   = 4'd9;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
    } md_req_t;

    // Opcodes 0 and 10-15 are handshaken but never reach the MD unit.
    function automatic logic is_valid_op(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_BDS);
    endfunction

    function automatic logic is_read_op(input logic [3:0] op);
        return (op == MD_MFHI) || (op == MD_MFLO);
    endfunction

endpackage

// File: rtl/md_req_fifo.sv
// Generic DEPTH-entry synchronous FIFO of MD requests with flush.
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
module md_req_fifo
    import md_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  md_req_t          wr_data,
    output md_req_t          rd_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    md_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Flush empties the queue by realigning both pointers to zero.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/md_dispatch.sv
// Request buffer in front of the MD unit: queues requests, issues them when the
// unit is free and returns mfhi/mflo data. MD_FWD_EN adds an empty-queue bypass.
module md_dispatch
    import md_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [31:0]      in_rs,
    input  logic [31:0]      in_rt,
    input  logic             flush,
    output logic [3:0]       md_op,
    output logic [31:0]      md_rs,
    output logic [31:0]      md_rt,
    input  logic             md_start,
    input  logic             md_busy,
    input  logic [31:0]      md_out,
    output logic             rd_valid,
    output logic [31:0]      rd_data,
    output logic [LVL_W-1:0] level
);

    md_req_t in_req;
    md_req_t head;
    md_req_t issued;
    logic    fifo_full;
    logic    fifo_empty;
    logic    start_guard;
    logic    can_issue;
    logic    issue_head;
    logic    bypass;
    logic    push;

    assign in_req     = '{op: in_op, rs: in_rs, rt: in_rt};
    assign in_ready   = ~fifo_full & ~flush;
    assign can_issue  = ~md_busy & ~start_guard & ~flush;
    assign issue_head = can_issue & ~fifo_empty;

`ifdef MD_FWD_EN
    assign bypass = can_issue & fifo_empty & in_valid & is_valid_op(in_op);
`else
    assign bypass = 1'b0;
`endif

    assign push = in_valid & in_ready & is_valid_op(in_op) & ~bypass;

    md_req_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (issue_head),
        .flush   (flush),
        .wr_data (in_req),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (level)
    );

    // Idle MD outputs are forced to zero so the unit sees MD_NONE.
    always_comb begin
        issued = '0;
        if (issue_head) begin
            issued = head;
        end else if (bypass) begin
            issued = in_req;
        end
    end

    assign md_op = issued.op;
    assign md_rs = issued.rs;
    assign md_rt = issued.rt;

    // MD busy lags its start by a cycle; start_guard covers that gap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            start_guard <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
        end else begin
            start_guard <= md_start;
            rd_valid    <= is_read_op(issued.op);
            if (is_read_op(issued.op)) begin
                rd_data <= md_out;
            end
        end
    end

endmodule
